// File: rtl/jtag_axi_burst_if_pkg.sv
// Shared types for the JTAG->AXI burst bridge: JTAG-side request/response records,
// AXI master bundles and the AXI-to-JTAG status mapping.
package jtag_axi_burst_if_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  localparam int JTAG_AXI_MAX_BURST_LEN = 16;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef logic [AXI_DATA_W-1:0] axi_data_t;

  typedef enum logic [1:0] {
    JTAG_AXI_OKAY   = 2'd0,
    JTAG_AXI_EXOKAY = 2'd1,
    JTAG_AXI_SLVERR = 2'd2,
    JTAG_AXI_DECERR = 2'd3
  } jtag_axi_status_e;

  typedef struct packed {
    logic                  txn_type;  // 1 = write
    logic [AXI_ADDR_W-1:0] addr;
    logic [2:0]            size;
    logic [7:0]            len;       // beats-1
  } s_jtag_axi_burst_req_t;

  typedef struct packed {
    axi_data_t        data_rd;
    jtag_axi_status_e status;
    logic             last;
  } s_jtag_axi_burst_resp_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   awid;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    axi_data_t             wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  bready;
    logic [AXI_ID_W-1:0]   arid;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                awready;
    logic                wready;
    logic [AXI_ID_W-1:0] bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                arready;
    logic [AXI_ID_W-1:0] rid;
    axi_data_t           rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
  } s_axi_miso_t;

  function automatic jtag_axi_status_e map_resp(input logic [1:0] resp);
    case (resp)
      2'b00:   return JTAG_AXI_OKAY;
      2'b01:   return JTAG_AXI_EXOKAY;
      2'b10:   return JTAG_AXI_SLVERR;
      default: return JTAG_AXI_DECERR;
    endcase
  endfunction

endpackage

// File: rtl/jtag_axi_burst_if_if.sv
// Bridge bus bundle: JTAG-side FIFO handshakes plus the AXI master channels.
// master = bridge core side, slave = FIFO/AXI environment side.
interface jtag_axi_burst_if_if;
  import jtag_axi_burst_if_pkg::*;

  logic                   fifo_req_empty;
  s_jtag_axi_burst_req_t  fifo_req;
  logic                   fifo_req_rd_en;
  logic                   fifo_wr_data_empty;
  axi_data_t              fifo_wr_data;
  logic                   fifo_wr_data_en;
  logic                   fifo_resp_full;
  s_jtag_axi_burst_resp_t fifo_resp;
  logic                   fifo_resp_wr_en;
  s_axi_mosi_t            jtag_axi_mosi_o;
  s_axi_miso_t            jtag_axi_miso_i;

  modport master (
    input  fifo_req_empty, fifo_req, fifo_wr_data_empty, fifo_wr_data,
           fifo_resp_full, jtag_axi_miso_i,
    output fifo_req_rd_en, fifo_wr_data_en, fifo_resp, fifo_resp_wr_en,
           jtag_axi_mosi_o
  );

  modport slave (
    output fifo_req_empty, fifo_req, fifo_wr_data_empty, fifo_wr_data,
           fifo_resp_full, jtag_axi_miso_i,
    input  fifo_req_rd_en, fifo_wr_data_en, fifo_resp, fifo_resp_wr_en,
           jtag_axi_mosi_o
  );

endinterface

// File: rtl/jtag_axi_burst_if_fifo.sv
// Small first-word-fall-through FIFO used as the order tracker and the W-tracker.
// Push while full is accepted only together with a pop.
module jtag_axi_burst_if_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign wr_ok = push && (!full || pop);
  assign rd_ok = pop && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jtag_axi_burst_if.sv
// JTAG->AXI master bridge core with INCR bursts, bounded outstanding transactions and
// in-order responses. Optional watchdog enabled by defining JTAG_AXI_TIMEOUT_EN.
module jtag_axi_burst_if
  import jtag_axi_burst_if_pkg::*;
#(
  parameter int AXI_MASTER_ID   = 0,
  parameter int MAX_OUTSTANDING = 4,
  parameter int MAX_BURST_LEN   = JTAG_AXI_MAX_BURST_LEN,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                               clk,
  input  logic                               ares,
  input  logic                               timeout_clr_i,
  output logic                               axi_timeout_o,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  jtag_axi_burst_if_if.master                bus
);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  function automatic logic [7:0] clamp_len(input logic [7:0] len);
    if (int'(len) >= MAX_BURST_LEN) return 8'(MAX_BURST_LEN - 1);
    return len;
  endfunction

  s_axi_miso_t           miso;
  s_axi_mosi_t           mosi;
  s_jtag_axi_burst_req_t req;
  logic [OW-1:0] outstanding;
  logic [7:0]    len_c;
  logic [7:0]    w_beat_cnt;
  logic [7:0]    r_beat_cnt;
  logic          run;
  logic          can_issue, awvalid, arvalid, wvalid, wlast, rready, bready;
  logic          aw_hs, ar_hs, addr_hs, w_hs, r_hs, b_hs, r_exp_last, ord_pop;
  logic [8:0]    ord_head;
  logic          ord_op, ord_empty, ord_full;
  logic [7:0]    ord_len, wtrk_len;
  logic          wtrk_empty, wtrk_full;

  assign miso  = bus.jtag_axi_miso_i;
  assign req   = bus.fifo_req;
  assign run   = !ares;
  assign len_c = clamp_len(req.len);

  // Address issue: one request at a time, limited by outstanding count and tracker space.
  assign can_issue = run && !bus.fifo_req_empty && (outstanding < OW'(MAX_OUTSTANDING)) && !ord_full;
  assign awvalid   = can_issue && req.txn_type;
  assign arvalid   = can_issue && !req.txn_type;
  assign aw_hs     = awvalid && miso.awready;
  assign ar_hs     = arvalid && miso.arready;
  assign addr_hs   = aw_hs || ar_hs;

  // W beats are only offered once their AW has been handshaken into the W-tracker.
  assign wvalid = run && !wtrk_empty && !bus.fifo_wr_data_empty;
  assign wlast  = (w_beat_cnt == wtrk_len);
  assign w_hs   = wvalid && miso.wready;

  assign ord_op     = ord_head[8];
  assign ord_len    = ord_head[7:0];
  assign rready     = run && !ord_empty && !ord_op && !bus.fifo_resp_full;
  assign bready     = run && !ord_empty && ord_op && !bus.fifo_resp_full;
  assign r_hs       = miso.rvalid && rready;
  assign b_hs       = miso.bvalid && bready;
  assign r_exp_last = (r_beat_cnt == ord_len);
  assign ord_pop    = (r_hs && r_exp_last) || b_hs;

  jtag_axi_burst_if_fifo #(.WIDTH(9), .DEPTH(MAX_OUTSTANDING)) u_order_trk (
    .clk(clk), .rst(ares), .push(addr_hs), .din({req.txn_type, len_c}),
    .pop(ord_pop), .dout(ord_head), .empty(ord_empty), .full(ord_full)
  );

  jtag_axi_burst_if_fifo #(.WIDTH(8), .DEPTH(MAX_OUTSTANDING)) u_w_trk (
    .clk(clk), .rst(ares), .push(aw_hs), .din(len_c),
    .pop(w_hs && wlast), .dout(wtrk_len), .empty(wtrk_empty), .full(wtrk_full)
  );

  always_comb begin
    mosi         = '0;
    mosi.awid    = AXI_ID_W'(AXI_MASTER_ID);
    mosi.awaddr  = req.addr;
    mosi.awlen   = len_c;
    mosi.awsize  = req.size;
    mosi.awburst = AXI_BURST_INCR;
    mosi.awvalid = awvalid;
    mosi.wdata   = bus.fifo_wr_data;
    mosi.wstrb   = '1;
    mosi.wlast   = wlast;
    mosi.wvalid  = wvalid;
    mosi.bready  = bready;
    mosi.arid    = AXI_ID_W'(AXI_MASTER_ID);
    mosi.araddr  = req.addr;
    mosi.arlen   = len_c;
    mosi.arsize  = req.size;
    mosi.arburst = AXI_BURST_INCR;
    mosi.arvalid = arvalid;
    mosi.rready  = rready;
  end

  // A protocol-level rlast mismatch is reported as SLVERR; framing follows the tracker.
  always_comb begin
    bus.fifo_resp = '0;
    if (r_hs) begin
      bus.fifo_resp.data_rd = miso.rdata;
      bus.fifo_resp.status  = (miso.rlast != r_exp_last) ? JTAG_AXI_SLVERR : map_resp(miso.rresp);
      bus.fifo_resp.last    = r_exp_last;
    end else begin
      bus.fifo_resp.status  = map_resp(miso.bresp);
      bus.fifo_resp.last    = 1'b1;
    end
  end

  assign bus.jtag_axi_mosi_o = mosi;
  assign bus.fifo_req_rd_en  = addr_hs;
  assign bus.fifo_wr_data_en = w_hs;
  assign bus.fifo_resp_wr_en = r_hs || b_hs;
  assign outstanding_o       = outstanding;

  always_ff @(posedge clk) begin
    if (ares) begin
      outstanding <= '0;
      w_beat_cnt  <= '0;
      r_beat_cnt  <= '0;
    end else begin
      case ({addr_hs, ord_pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
      if (w_hs) w_beat_cnt <= wlast ? 8'd0 : w_beat_cnt + 8'd1;
      if (r_hs) r_beat_cnt <= r_exp_last ? 8'd0 : r_beat_cnt + 8'd1;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{wtrk_full, miso.bid, miso.rid};

`ifdef JTAG_AXI_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic        any_hs;

  assign any_hs = addr_hs || w_hs || r_hs || b_hs;

  // Watchdog: counts idle cycles while work is pending; clear beats a same-cycle set.
  always_ff @(posedge clk) begin
    if (ares) begin
      wd_cnt        <= '0;
      axi_timeout_o <= 1'b0;
    end else begin
      if ((outstanding == '0) || any_hs) wd_cnt <= '0;
      else                               wd_cnt <= wd_cnt + 32'd1;
      if (timeout_clr_i)                            axi_timeout_o <= 1'b0;
      else if (wd_cnt == 32'(TIMEOUT_CYCLES - 1))   axi_timeout_o <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg    = ^{timeout_clr_i, TIMEOUT_CYCLES[0]};
  assign axi_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_axi_burst_if.sv
// Directed bench for jtag_axi_burst_if: expected responses are queued when slave beats are
// driven and compared when the bridge pushes into the response FIFO.
module tb_jtag_axi_burst_if;
  import jtag_axi_burst_if_pkg::*;

  logic       clk;
  logic       ares;
  logic       timeout_clr;
  logic       axi_timeout;
  logic [2:0] outstanding;
  int         checks   = 0;
  int         failures = 0;
  int         ar_cnt;
  s_jtag_axi_burst_resp_t exp_q[$];

  jtag_axi_burst_if_if bus ();

  jtag_axi_burst_if #(
    .AXI_MASTER_ID(0), .MAX_OUTSTANDING(4), .MAX_BURST_LEN(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .ares(ares), .timeout_clr_i(timeout_clr), .axi_timeout_o(axi_timeout),
    .outstanding_o(outstanding), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic wr, input logic [31:0] addr, input logic [7:0] len);
    bus.fifo_req       = '{txn_type: wr, addr: addr, size: 3'd2, len: len};
    bus.fifo_req_empty = 1'b0;
  endtask

  task automatic r_beat(input logic [31:0] d, input logic [1:0] resp, input logic rlast);
    bus.jtag_axi_miso_i.rvalid = 1'b1;
    bus.jtag_axi_miso_i.rdata  = d;
    bus.jtag_axi_miso_i.rresp  = resp;
    bus.jtag_axi_miso_i.rlast  = rlast;
  endtask

  task automatic exp_resp(input logic [31:0] d, input jtag_axi_status_e st, input logic last);
    exp_q.push_back('{data_rd: d, status: st, last: last});
  endtask

  always @(negedge clk) begin : resp_mon
    s_jtag_axi_burst_resp_t e;
    if (bus.fifo_resp_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 64'(bus.fifo_resp_wr_en), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("resp", 64'(bus.fifo_resp), 64'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL tb_timeout observed=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    jtag_axi_status_e st;
    ares                   = 1'b1;
    timeout_clr            = 1'b0;
    bus.fifo_req_empty     = 1'b1;
    bus.fifo_req           = '0;
    bus.fifo_wr_data_empty = 1'b1;
    bus.fifo_wr_data       = '0;
    bus.fifo_resp_full     = 1'b0;
    bus.jtag_axi_miso_i    = '0;
    repeat (2) tick();
    chk("rst_awvalid", 64'(bus.jtag_axi_mosi_o.awvalid), 64'(0));
    chk("rst_arvalid", 64'(bus.jtag_axi_mosi_o.arvalid), 64'(0));
    chk("rst_wvalid", 64'(bus.jtag_axi_mosi_o.wvalid), 64'(0));
    chk("rst_rready", 64'(bus.jtag_axi_mosi_o.rready), 64'(0));
    chk("rst_bready", 64'(bus.jtag_axi_mosi_o.bready), 64'(0));
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    chk("rst_timeout", 64'(axi_timeout), 64'(0));
    ares = 1'b0;
    tick();

    // 1: read len=3
    set_req(1'b0, 32'h1000, 8'd3);
    bus.jtag_axi_miso_i.arready = 1'b1;
    #1;
    chk("t1_arvalid", 64'(bus.jtag_axi_mosi_o.arvalid), 64'(1));
    chk("t1_arlen", 64'(bus.jtag_axi_mosi_o.arlen), 64'(3));
    chk("t1_arburst", 64'(bus.jtag_axi_mosi_o.arburst), 64'(1));
    chk("t1_arsize", 64'(bus.jtag_axi_mosi_o.arsize), 64'(2));
    chk("t1_arid", 64'(bus.jtag_axi_mosi_o.arid), 64'(0));
    chk("t1_req_rd_en", 64'(bus.fifo_req_rd_en), 64'(1));
    tick();
    bus.fifo_req_empty = 1'b1;
    bus.jtag_axi_miso_i.arready = 1'b0;
    #1;
    chk("t1_outstanding_1", 64'(outstanding), 64'(1));
    for (int i = 0; i < 4; i++) begin
      r_beat(32'hA0 + 32'(i), 2'b00, (i == 3));
      exp_resp(32'hA0 + 32'(i), JTAG_AXI_OKAY, (i == 3));
      #1;
      chk("t1_rready", 64'(bus.jtag_axi_mosi_o.rready), 64'(1));
      tick();
    end
    bus.jtag_axi_miso_i.rvalid = 1'b0;
    #1;
    chk("t1_outstanding_0", 64'(outstanding), 64'(0));

    // 2: write len=1
    set_req(1'b1, 32'h2000, 8'd1);
    bus.jtag_axi_miso_i.awready = 1'b1;
    #1;
    chk("t2_awvalid", 64'(bus.jtag_axi_mosi_o.awvalid), 64'(1));
    chk("t2_awlen", 64'(bus.jtag_axi_mosi_o.awlen), 64'(1));
    chk("t2_w_before_aw", 64'(bus.jtag_axi_mosi_o.wvalid), 64'(0));
    tick();
    bus.fifo_req_empty          = 1'b1;
    bus.jtag_axi_miso_i.awready = 1'b0;
    bus.jtag_axi_miso_i.wready  = 1'b1;
    bus.fifo_wr_data            = 32'h11;
    bus.fifo_wr_data_empty      = 1'b0;
    #1;
    chk("t2_wvalid", 64'(bus.jtag_axi_mosi_o.wvalid), 64'(1));
    chk("t2_wdata0", 64'(bus.jtag_axi_mosi_o.wdata), 64'h11);
    chk("t2_wlast0", 64'(bus.jtag_axi_mosi_o.wlast), 64'(0));
    chk("t2_wstrb", 64'(bus.jtag_axi_mosi_o.wstrb), 64'hF);
    chk("t2_wr_data_en", 64'(bus.fifo_wr_data_en), 64'(1));
    tick();
    bus.fifo_wr_data = 32'h22;
    #1;
    chk("t2_wdata1", 64'(bus.jtag_axi_mosi_o.wdata), 64'h22);
    chk("t2_wlast1", 64'(bus.jtag_axi_mosi_o.wlast), 64'(1));
    tick();
    bus.fifo_wr_data_empty = 1'b1;
    bus.jtag_axi_miso_i.bvalid = 1'b1;
    bus.jtag_axi_miso_i.bresp  = 2'b00;
    exp_resp(32'h0, JTAG_AXI_OKAY, 1'b1);
    #1;
    chk("t2_wvalid_done", 64'(bus.jtag_axi_mosi_o.wvalid), 64'(0));
    chk("t2_bready", 64'(bus.jtag_axi_mosi_o.bready), 64'(1));
    chk("t2_rready_off", 64'(bus.jtag_axi_mosi_o.rready), 64'(0));
    tick();
    bus.jtag_axi_miso_i.bvalid = 1'b0;
    #1;
    chk("t2_outstanding_0", 64'(outstanding), 64'(0));

    // 3: outstanding limit
    set_req(1'b0, 32'h3000, 8'd0);
    bus.jtag_axi_miso_i.arready = 1'b1;
    ar_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.jtag_axi_mosi_o.arvalid && bus.jtag_axi_miso_i.arready) ar_cnt++;
      tick();
    end
    chk("t3_ar_hs_count", 64'(ar_cnt), 64'(4));
    chk("t3_outstanding_max", 64'(outstanding), 64'(4));
    r_beat(32'h300, 2'b00, 1'b1);
    exp_resp(32'h300, JTAG_AXI_OKAY, 1'b1);
    #1;
    chk("t3_ar_blocked", 64'(bus.jtag_axi_mosi_o.arvalid), 64'(0));
    tick();
    bus.jtag_axi_miso_i.rvalid = 1'b0;
    #1;
    chk("t3_ar_5th_issue", 64'(bus.jtag_axi_mosi_o.arvalid), 64'(1));
    tick();
    chk("t3_ar_blocked_again", 64'(bus.jtag_axi_mosi_o.arvalid), 64'(0));
    r_beat(32'h301, 2'b00, 1'b1);
    exp_resp(32'h301, JTAG_AXI_OKAY, 1'b1);
    tick();
    bus.jtag_axi_miso_i.rvalid = 1'b0;
    #1;
    chk("t3_ar_6th_issue", 64'(bus.jtag_axi_mosi_o.arvalid), 64'(1));
    tick();
    bus.fifo_req_empty = 1'b1;
    bus.jtag_axi_miso_i.arready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      r_beat(32'h302 + 32'(k), 2'b00, 1'b1);
      exp_resp(32'h302 + 32'(k), JTAG_AXI_OKAY, 1'b1);
      tick();
    end
    bus.jtag_axi_miso_i.rvalid = 1'b0;
    #1;
    chk("t3_outstanding_0", 64'(outstanding), 64'(0));

    // 4: early rlast
    set_req(1'b0, 32'h4000, 8'd1);
    bus.jtag_axi_miso_i.arready = 1'b1;
    tick();
    bus.fifo_req_empty = 1'b1;
    bus.jtag_axi_miso_i.arready = 1'b0;
    r_beat(32'hB0, 2'b00, 1'b1);
    exp_resp(32'hB0, JTAG_AXI_SLVERR, 1'b0);
    tick();
    chk("t4_not_popped", 64'(outstanding), 64'(1));
    r_beat(32'hB1, 2'b00, 1'b1);
    exp_resp(32'hB1, JTAG_AXI_OKAY, 1'b1);
    tick();
    bus.jtag_axi_miso_i.rvalid = 1'b0;
    #1;
    chk("t4_outstanding_0", 64'(outstanding), 64'(0));

    // clamp to MAX_BURST_LEN-1 and status mapping
    set_req(1'b0, 32'h5000, 8'd200);
    bus.jtag_axi_miso_i.arready = 1'b1;
    #1;
    chk("clamp_arlen", 64'(bus.jtag_axi_mosi_o.arlen), 64'(15));
    tick();
    bus.fifo_req_empty = 1'b1;
    bus.jtag_axi_miso_i.arready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0:       st = JTAG_AXI_OKAY;
        1:       st = JTAG_AXI_EXOKAY;
        2:       st = JTAG_AXI_SLVERR;
        default: st = JTAG_AXI_DECERR;
      endcase
      r_beat(32'h500 + 32'(i), 2'(i % 4), (i == 15));
      exp_resp(32'h500 + 32'(i), st, (i == 15));
      tick();
    end
    bus.jtag_axi_miso_i.rvalid = 1'b0;
    #1;
    chk("clamp_outstanding_0", 64'(outstanding), 64'(0));

    // 5: response FIFO backpressure
    set_req(1'b0, 32'h5800, 8'd0);
    bus.jtag_axi_miso_i.arready = 1'b1;
    tick();
    bus.fifo_req_empty = 1'b1;
    bus.jtag_axi_miso_i.arready = 1'b0;
    bus.fifo_resp_full = 1'b1;
    r_beat(32'hC0, 2'b00, 1'b1);
    #1;
    chk("t5_rready_full", 64'(bus.jtag_axi_mosi_o.rready), 64'(0));
    chk("t5_no_push", 64'(bus.fifo_resp_wr_en), 64'(0));
    tick();
    bus.fifo_resp_full = 1'b0;
    exp_resp(32'hC0, JTAG_AXI_OKAY, 1'b1);
    #1;
    chk("t5_rready_free", 64'(bus.jtag_axi_mosi_o.rready), 64'(1));
    tick();
    bus.jtag_axi_miso_i.rvalid = 1'b0;
    #1;
    chk("t5_outstanding_0", 64'(outstanding), 64'(0));

    // 6: watchdog and reset mid-burst
    set_req(1'b0, 32'h6000, 8'd3);
    bus.jtag_axi_miso_i.arready = 1'b1;
    tick();
    bus.fifo_req_empty = 1'b1;
    bus.jtag_axi_miso_i.arready = 1'b0;
`ifdef JTAG_AXI_TIMEOUT_EN
    repeat (7) tick();
    chk("t6_timeout_early", 64'(axi_timeout), 64'(0));
    tick();
    chk("t6_timeout_set", 64'(axi_timeout), 64'(1));
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    chk("t6_timeout_cleared", 64'(axi_timeout), 64'(0));
`else
    repeat (12) tick();
    chk("t6_timeout_tied", 64'(axi_timeout), 64'(0));
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    chk("t6_timeout_clr_ignored", 64'(axi_timeout), 64'(0));
`endif
    r_beat(32'h60, 2'b00, 1'b0);
    exp_resp(32'h60, JTAG_AXI_OKAY, 1'b0);
    tick();
    ares = 1'b1;
    set_req(1'b1, 32'h6100, 8'd2);
    bus.jtag_axi_miso_i.awready = 1'b1;
    bus.jtag_axi_miso_i.arready = 1'b1;
    bus.fifo_wr_data_empty = 1'b0;
    r_beat(32'h61, 2'b00, 1'b0);
    #1;
    chk("t6_rst_awvalid", 64'(bus.jtag_axi_mosi_o.awvalid), 64'(0));
    chk("t6_rst_rready", 64'(bus.jtag_axi_mosi_o.rready), 64'(0));
    chk("t6_rst_req_rd_en", 64'(bus.fifo_req_rd_en), 64'(0));
    chk("t6_rst_resp_wr_en", 64'(bus.fifo_resp_wr_en), 64'(0));
    tick();
    chk("t6_rst_outstanding", 64'(outstanding), 64'(0));
    chk("t6_rst_timeout", 64'(axi_timeout), 64'(0));
    chk("t6_rst_wvalid", 64'(bus.jtag_axi_mosi_o.wvalid), 64'(0));
    ares = 1'b0;
    bus.fifo_req_empty = 1'b1;
    bus.jtag_axi_miso_i.rvalid = 1'b0;
    bus.jtag_axi_miso_i.awready = 1'b0;
    bus.fifo_wr_data_empty = 1'b1;
    #1;
    chk("t6_post_rst_rready", 64'(bus.jtag_axi_mosi_o.rready), 64'(0));
    chk("t6_post_rst_wvalid", 64'(bus.jtag_axi_mosi_o.wvalid), 64'(0));
    set_req(1'b0, 32'h7000, 8'd0);
    tick();
    bus.fifo_req_empty = 1'b1;
    bus.jtag_axi_miso_i.arready = 1'b0;
    r_beat(32'h70, 2'b00, 1'b1);
    exp_resp(32'h70, JTAG_AXI_OKAY, 1'b1);
    tick();
    bus.jtag_axi_miso_i.rvalid = 1'b0;
    #1;
    chk("t6_post_rst_outstanding", 64'(outstanding), 64'(0));

    repeat (2) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
